// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative 64-bit multiply/divide unit for the EXE stage (RV64M ops).
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes and fix up the signs when the result is written.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle full multiplier. Division stays iterative in both builds.
// Handshake: start is a request valid. It is accepted on an edge where the block is
// IDLE and flush is low. busy is the stall towards the EXE pipeline register. It is
// high for a requesting cycle in IDLE and for every MUL/DIV cycle. out_valid pulses
// for one cycle in DONE, and result/rd_out then hold until the next DONE.
module exe_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        out_valid,
    output logic [63:0] result,
    output logic [4:0]  rd_out,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_n;
    logic        accept;
    logic        w_q, neg_q, rneg_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [6:0]  cnt;
    logic [63:0] acc_hi, acc_lo, opnd;

    logic        in_w, in_div, in_illegal, sgn_a, sgn_b, a_neg, b_neg;
    logic        div_zero, div_ovf, is_special;
    logic [2:0]  in_f3;
    logic [63:0] ext_a, ext_b, mag_a, mag_b, spec_res;

    logic [64:0] mul_sum, div_sh, div_diff;
    logic        div_ge;
    logic [63:0] step_hi, step_lo, quo_s, rem_s, dv, dv_res, fin_res;
    logic [127:0] prod;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Sign-fix a 128-bit product, pick the low or high half, then apply W sign extension.
    function automatic logic [63:0] fmt_mul(input logic [127:0] p, input logic w,
                                            input logic [2:0] f3, input logic neg);
        logic [127:0] s;
        logic [63:0]  r;
        s = neg ? (~p + 128'd1) : p;
        r = (f3 == 3'b000) ? s[63:0] : s[127:64];
        return w ? sext32(r[31:0]) : r;
    endfunction

    // Decode the incoming request: operand extension, magnitudes and the cases that skip iteration.
    always_comb begin
        in_w       = op[3];
        in_f3      = op[2:0];
        in_div     = op[2];
        in_illegal = in_w & ~in_f3[2] & (in_f3[1:0] != 2'b00);
        sgn_a      = (in_f3 == 3'b001) | (in_f3 == 3'b010) | (in_f3 == 3'b100) | (in_f3 == 3'b110);
        sgn_b      = (in_f3 == 3'b001) | (in_f3 == 3'b100) | (in_f3 == 3'b110);
        ext_a      = in_w ? (sgn_a ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
        ext_b      = in_w ? (sgn_b ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
        a_neg      = sgn_a & ext_a[63];
        b_neg      = sgn_b & ext_b[63];
        mag_a      = a_neg ? (~ext_a + 64'd1) : ext_a;
        mag_b      = b_neg ? (~ext_b + 64'd1) : ext_b;
        div_zero   = in_div & (ext_b == 64'd0);
        div_ovf    = in_div & sgn_a & (ext_b == {64{1'b1}}) &
                     (ext_a == (in_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        spec_res   = 64'd0;
        if (div_zero)
            spec_res = in_f3[1] ? ext_a : {64{1'b1}};
        else if (div_ovf)
            spec_res = in_f3[1] ? 64'd0 : ext_a;
        if (in_w)
            spec_res = sext32(spec_res[31:0]);
        is_special = in_illegal | div_zero | div_ovf;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [127:0] fast_prod;
    logic [63:0]  fast_res;
    // Single-cycle full multiply of the magnitudes, formatted at accept.
    always_comb begin
        fast_prod = {64'b0, mag_a} * {64'b0, mag_b};
        fast_res  = fmt_mul(fast_prod, in_w, in_f3, a_neg ^ b_neg);
    end
`endif

    // One iteration step of either engine plus the formatted result after the final step.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 65'd0);
        div_sh   = {acc_hi, acc_lo[63]};
        div_diff = div_sh - {1'b0, opnd};
        div_ge   = ~div_diff[64];
        if (state == MUL) begin
            step_hi = mul_sum[64:1];
            step_lo = {mul_sum[0], acc_lo[63:1]};
        end else begin
            step_hi = div_ge ? div_diff[63:0] : div_sh[63:0];
            step_lo = {acc_lo[62:0], div_ge};
        end
        // W multiplies stop 32 shifts early, so their product sits 32 bits higher.
        prod    = w_q ? {32'b0, step_hi, step_lo[63:32]} : {step_hi, step_lo};
        quo_s   = neg_q ? (~step_lo + 64'd1) : step_lo;
        rem_s   = rneg_q ? (~step_hi + 64'd1) : step_hi;
        dv      = f3_q[1] ? rem_s : quo_s;
        dv_res  = w_q ? sext32(dv[31:0]) : dv;
        fin_res = (state == MUL) ? fmt_mul(prod, w_q, f3_q, neg_q) : dv_res;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_n = state;
        accept  = (state == IDLE) & start & ~flush;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_special)
                        state_n = DONE;
                    else if (in_div)
                        state_n = DIV;
                    else
`ifdef MULDIV_FAST_MUL_EN
                        state_n = DONE;
`else
                        state_n = MUL;
`endif
                end
            end
            MUL, DIV: if (cnt == 7'd1) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
        busy      = rst & ((start & (state == IDLE)) | (state == MUL) | (state == DIV));
        out_valid = (state == DONE) & ~flush;
        dbg_state = state;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Operand capture, iteration datapath and result/tag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q    <= 1'b0;
            f3_q   <= 3'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            rd_q   <= 5'd0;
            cnt    <= 7'd0;
            acc_hi <= 64'd0;
            acc_lo <= 64'd0;
            opnd   <= 64'd0;
            result <= 64'd0;
            rd_out <= 5'd0;
        end else if (accept) begin
            w_q    <= in_w;
            f3_q   <= in_f3;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            rd_q   <= rd_in;
            cnt    <= in_w ? 7'd32 : 7'd64;
            acc_hi <= 64'd0;
            if (in_div) begin
                // W dividends are parked in the top half so 32 shifts consume them.
                acc_lo <= in_w ? {mag_a[31:0], 32'b0} : mag_a;
                opnd   <= mag_b;
            end else begin
                acc_lo <= mag_b;
                opnd   <= mag_a;
            end
            if (is_special) begin
                result <= spec_res;
                rd_out <= rd_in;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!in_div) begin
                result <= fast_res;
                rd_out <= rd_in;
            end
`endif
        end else if ((state == MUL || state == DIV) && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 7'd1;
            if (cnt == 7'd1) begin
                result <= fin_res;
                rd_out <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed checks of exe_muldiv covering reset, multiply and divide
// variants, the divide special cases, flush, ignored start and mid-operation reset.
module tb_exe_muldiv;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [3:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        out_valid;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic [1:0]  dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 65;
    localparam int MULW_LAT = 33;
`endif

    exe_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_in     (rd_in),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .rd_out    (rd_out),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

    // Driver: issue one request and wait (bounded) for out_valid.
    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output int lat, output logic [63:0] res,
                          output logic [4:0] rdo, output logic busy_hi);
        @(negedge clk);
        op = o; src1 = a; src2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; res = '0; rdo = '0; busy_hi = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; res = result; rdo = rd_out;
                break;
            end
            if (!busy) busy_hi = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; start = 1'b1; op = 4'b0101; src1 = 64'd5; src2 = 64'd0; rd_in = 5'd3;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
        total_cnt++; if (rd_out !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rd_out); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
        // Release with start already high: first edge after release must accept.
        rst = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL first_accept_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL first_accept_result: got %h want ffffffffffffffff", result); else pass_cnt++;
        total_cnt++; if (rd_out !== 5'd3) $display("FAIL first_accept_rd: got %0d want 3", rd_out); else pass_cnt++;
    endtask

    task automatic test_mul;
        int lat; logic [63:0] res; logic [4:0] rdo; logic bh;
        run_op(4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, lat, res, rdo, bh);
        total_cnt++; if (lat != MUL_LAT) $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mul_result: got %h want ffffffffffffffeb", res); else pass_cnt++;
        total_cnt++; if (rdo !== 5'd5) $display("FAIL mul_rd: got %0d want 5", rdo); else pass_cnt++;
        total_cnt++; if (bh !== 1'b1) $display("FAIL mul_busy_held: got %b want 1", bh); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL done_busy: got %b want 0", busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL valid_pulse: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL result_hold: got %h want ffffffffffffffeb", result); else pass_cnt++;

        run_op(4'b0011, {64{1'b1}}, {64{1'b1}}, 5'd6, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat != MUL_LAT) $display("FAIL mulhu: got %h lat %0d want fffffffffffffffe lat %0d", res, lat, MUL_LAT); else pass_cnt++;
        run_op(4'b0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd7, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mulh: got %h want ffffffffffffffff", res); else pass_cnt++;
        run_op(4'b0010, 64'd2, {64{1'b1}}, 5'd8, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd1) $display("FAIL mulhsu_pos: got %h want 1", res); else pass_cnt++;
        run_op(4'b0010, {64{1'b1}}, 64'd2, 5'd8, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mulhsu_neg: got %h want ffffffffffffffff", res); else pass_cnt++;
        run_op(4'b1000, 64'hABCD_0000_4000_0000, 64'd2, 5'd9, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_8000_0000 || lat != MULW_LAT) $display("FAIL mulw: got %h lat %0d want ffffffff80000000 lat %0d", res, lat, MULW_LAT); else pass_cnt++;
    endtask

    task automatic test_div;
        int lat; logic [63:0] res; logic [4:0] rdo; logic bh;
        run_op(4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 65) $display("FAIL div_neg: got %h lat %0d want fffffffffffffffd lat 65", res, lat); else pass_cnt++;
        total_cnt++; if (bh !== 1'b1) $display("FAIL div_busy_held: got %b want 1", bh); else pass_cnt++;
        run_op(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rem_neg: got %h want ffffffffffffffff", res); else pass_cnt++;
        run_op(4'b0110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd10, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd1) $display("FAIL rem_negdivisor: got %h want 1", res); else pass_cnt++;
        run_op(4'b0101, 64'd100, 64'd7, 5'd11, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd14) $display("FAIL divu: got %h want e", res); else pass_cnt++;
        run_op(4'b0111, 64'd100, 64'd7, 5'd11, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd2) $display("FAIL remu: got %h want 2", res); else pass_cnt++;
        run_op(4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd12, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 33) $display("FAIL divw: got %h lat %0d want fffffffffffffffd lat 33", res, lat); else pass_cnt++;
        run_op(4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 33) $display("FAIL remw: got %h lat %0d want ffffffffffffffff lat 33", res, lat); else pass_cnt++;
    endtask

    task automatic test_special;
        int lat; logic [63:0] res; logic [4:0] rdo; logic bh;
        run_op(4'b0100, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd14, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'h8000_0000_0000_0000 || lat != 1) $display("FAIL div_ovf: got %h lat %0d want 8000000000000000 lat 1", res, lat); else pass_cnt++;
        total_cnt++; if (rdo !== 5'd14) $display("FAIL div_ovf_rd: got %0d want 14", rdo); else pass_cnt++;
        run_op(4'b0110, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd15, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd0 || lat != 1) $display("FAIL rem_ovf: got %h lat %0d want 0 lat 1", res, lat); else pass_cnt++;
        run_op(4'b1101, 64'hFFFF_FFFF_0000_0009, 64'd0, 5'd16, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 1) $display("FAIL divuw_zero: got %h lat %0d want ffffffffffffffff lat 1", res, lat); else pass_cnt++;
        run_op(4'b1111, 64'hFFFF_FFFF_0000_0009, 64'd0, 5'd17, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd9 || lat != 1) $display("FAIL remuw_zero: got %h lat %0d want 9 lat 1", res, lat); else pass_cnt++;
        run_op(4'b1100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd18, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'hFFFF_FFFF_8000_0000 || lat != 1) $display("FAIL divw_ovf: got %h lat %0d want ffffffff80000000 lat 1", res, lat); else pass_cnt++;
        run_op(4'b1001, 64'd5, 64'd6, 5'd19, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd0 || lat != 1) $display("FAIL illegal_op: got %h lat %0d want 0 lat 1", res, lat); else pass_cnt++;
        total_cnt++; if (rdo !== 5'd19) $display("FAIL illegal_rd: got %0d want 19", rdo); else pass_cnt++;
    endtask

    task automatic test_flush;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        op = 4'b0100; src1 = 64'd100; src2 = 64'd7; rd_in = 5'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        flush = 1'b1;
        if (out_valid) seen = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        total_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_valid: got %b want 0", seen); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else pass_cnt++;
        op = 4'b0111; src1 = 64'd42; src2 = 64'd0; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || result !== 64'd42 || rd_out !== 5'd9) $display("FAIL flush_restart: got v=%b res=%h rd=%0d want v=1 res=2a rd=9", out_valid, result, rd_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat; logic [63:0] res; logic [4:0] rdo; logic bh;
        lat = -1;
        @(negedge clk);
        op = 4'b0101; src1 = 64'd100; src2 = 64'd7; rd_in = 5'd11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            if (n == 5) begin
                op = 4'b0000; src1 = 64'd3; src2 = 64'd3; rd_in = 5'd2; start = 1'b1;
            end
            if (n == 8) start = 1'b0;
        end
        total_cnt++; if (lat != 65) $display("FAIL ignore_latency: got %0d want 65", lat); else pass_cnt++;
        total_cnt++; if (result !== 64'd14 || rd_out !== 5'd11) $display("FAIL ignore_result: got %h rd %0d want e rd 11", result, rd_out); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0 || result !== 64'd14) $display("FAIL ignore_hold: got v=%b res=%h want v=0 res=e", out_valid, result); else pass_cnt++;
        run_op(4'b0111, 64'd100, 64'd7, 5'd12, lat, res, rdo, bh);
        total_cnt++; if (res !== 64'd2 || rdo !== 5'd12) $display("FAIL b2b_remu: got %h rd %0d want 2 rd 12", res, rdo); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        op = 4'b0100; src1 = 64'd1000; src2 = 64'd3; rd_in = 5'd21; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rstmid_ctrl: got busy=%b valid=%b want 0 0", busy, out_valid); else pass_cnt++;
        total_cnt++; if (result !== 64'd0 || rd_out !== 5'd0) $display("FAIL rstmid_data: got %h rd %0d want 0 rd 0", result, rd_out); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_no_valid: got %b want 0", seen); else pass_cnt++;
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
